pcihellocore_led_driver: RTL and testbench

PCIHELLOCORE_LED_DRIVER -- requirements
Module: pcihellocore_led_driver

---
 rtl/pcihellocore_led_pkg.sv | 35 +++
 rtl/pcihellocore_led_tick.sv | 27 ++
 rtl/pcihellocore_led_driver.sv | 87 ++++++++
 tb/tb_pcihellocore_led_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcihellocore_led_pkg.sv
// Field layout of the LEDG PIO control word and shared constants for the LED driver.
package pcihellocore_led_pkg;

    localparam int ENABLE_LSB = 0;
    localparam int ENABLE_W   = 9;
    localparam int BLINK_BIT  = 9;
    localparam int INVERT_BIT = 10;
    localparam int DIM_LSB    = 12;
    localparam int DIM_W      = 4;
    localparam int HALF_LSB   = 16;
    localparam int HALF_W     = 8;

    localparam logic [31:0] RESET_WORD = 32'h0000_000F;
    localparam int          PWM_BITS   = 4;

    typedef struct packed {
        logic [HALF_W-1:0]   half;
        logic [DIM_W-1:0]    dim;
        logic                invert;
        logic                blink;
        logic [ENABLE_W-1:0] enable;
    } led_ctrl_t;

    // Only the decoded fields are kept, so ignored word bits never count as a change.
    function automatic led_ctrl_t decode_word(input logic [31:0] word);
        led_ctrl_t c;
        c.enable = word[ENABLE_LSB +: ENABLE_W];
        c.blink  = word[BLINK_BIT];
        c.invert = word[INVERT_BIT];
        c.dim    = word[DIM_LSB +: DIM_W];
        c.half   = word[HALF_LSB +: HALF_W];
        return c;
    endfunction

endpackage

// File: rtl/pcihellocore_led_tick.sv
// Blink-tick prescaler: counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
module pcihellocore_led_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/pcihellocore_led_driver.sv
// LED driver for the PCI hello core: latches the PIO control word at PWM wrap and
// drives masked, dimmed, blinking and optionally inverted LEDs.
module pcihellocore_led_driver
    import pcihellocore_led_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int NUM_LEDS = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         led_word,
    output logic [NUM_LEDS-1:0] ledg,
    output logic                update_p
);

    localparam led_ctrl_t          RESET_CTRL = decode_word(RESET_WORD);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    led_ctrl_t           active;
    led_ctrl_t           next_ctrl;
    logic [HALF_W-1:0]   blink_cnt;
    logic                phase;
    logic                tick;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] led_next;
    logic                unused_word_bits;

    assign next_ctrl        = decode_word(led_word);
    assign unused_word_bits = ^{led_word[31:24], led_word[11]};

    pcihellocore_led_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // New settings only take effect at PWM wrap so a dim period is never cut short.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt  <= '0;
            active   <= RESET_CTRL;
            update_p <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == PWM_LAST) begin
                active   <= next_ctrl;
                update_p <= (next_ctrl != active);
            end else begin
                update_p <= 1'b0;
            end
        end
    end

    // Using >= rather than == lets a lowered half-period toggle on the very next tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (!active.blink) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (tick) begin
            if (blink_cnt >= active.half) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign pwm_on   = (pwm_cnt >= active.dim);
    assign led_next = {NUM_LEDS{active.invert}}
                    ^ (active.enable[NUM_LEDS-1:0] & {NUM_LEDS{pwm_on & phase}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ledg <= '0;
        end else begin
            ledg <= led_next;
        end
    end

endmodule

// File: tb/tb_pcihellocore_led_driver.sv
// Scoreboard bench for pcihellocore_led_driver: directed words with hand-computed
// per-cycle expectations, checked by an independent negedge monitor.
module tb_pcihellocore_led_driver;

    localparam int TICK_DIV = 4;

    typedef struct {
        int         epoch;
        int         e;
        logic [8:0] ledg;
        logic       upd;
        string      name;
    } exp_t;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [31:0] led_word = 32'h0000_0ABC;
    logic [8:0]  ledg9;
    logic [3:0]  ledg4;
    logic        upd9;
    logic        upd4;

    int   e;
    int   epoch;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    pcihellocore_led_driver #(
        .TICK_DIV (TICK_DIV),
        .NUM_LEDS (9)
    ) dut9 (
        .clk      (clk),
        .reset_n  (reset_n),
        .led_word (led_word),
        .ledg     (ledg9),
        .update_p (upd9)
    );

    pcihellocore_led_driver #(
        .TICK_DIV (TICK_DIV),
        .NUM_LEDS (4)
    ) dut4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .led_word (led_word),
        .ledg     (ledg4),
        .update_p (upd4)
    );

    // Edge counter since reset release; ledg at edge e uses pwm_cnt (e-1)%16.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) e <= 0;
        else          e <= e + 1;
    end

    task automatic push_exp(input int ep, input int at, input logic [8:0] lv,
                            input logic uv, input string nm);
        exp_t x;
        x.epoch = ep;
        x.e     = at;
        x.ledg  = lv;
        x.upd   = uv;
        x.name  = nm;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input logic [31:0] w);
        led_word = w;
        $display("[TB] e=%0d led_word <= %h", e, w);
    endtask

    task automatic checkOutput(input exp_t x);
        n_checks++;
        if (ledg9 !== x.ledg) begin
            n_fail++;
            $display("[TB] FAIL %s ledg9 e=%0d got %h want %h", x.name, e, ledg9, x.ledg);
        end
        n_checks++;
        if (ledg4 !== x.ledg[3:0]) begin
            n_fail++;
            $display("[TB] FAIL %s ledg4 e=%0d got %h want %h", x.name, e, ledg4, x.ledg[3:0]);
        end
        n_checks++;
        if (upd9 !== x.upd) begin
            n_fail++;
            $display("[TB] FAIL %s update_p9 e=%0d got %b want %b", x.name, e, upd9, x.upd);
        end
        n_checks++;
        if (upd4 !== x.upd) begin
            n_fail++;
            $display("[TB] FAIL %s update_p4 e=%0d got %b want %b", x.name, e, upd4, x.upd);
        end
    endtask

    // Monitor: pops the expectation whose edge index matches the current one.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].epoch == epoch && sb[0].e < e) begin
            cur = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s missed at e=%0d (now %0d)", cur.name, cur.e, e);
        end
        if (sb.size() > 0 && sb[0].epoch == epoch && sb[0].e == e) begin
            cur = sb.pop_front();
            checkOutput(cur);
        end
    end

    task automatic wait_e(input int target);
        int guard;
        guard = 0;
        @(negedge clk);
        while (e != target) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                $display("[TB] FAIL wait_e timeout target=%0d got %0d", target, e);
                $fatal(1, "[TB] stimulus stalled");
            end
        end
    endtask

    initial begin
        // Reset held with an arbitrary word on the bus.
        push_exp(0, 0, 9'h000, 1'b0, "reset_hold");
        repeat (3) @(negedge clk);
        applyStimulus(32'h0000_000F);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        epoch   = 1;
        push_exp(1, 1,  9'h00F, 1'b0, "first_edge");
        push_exp(1, 2,  9'h00F, 1'b0, "reset_word");
        push_exp(1, 16, 9'h00F, 1'b0, "same_word_load");
        push_exp(1, 17, 9'h00F, 1'b0, "same_word_after");

        // Change seen while pwm_cnt = 3: load 13 edges later, ledg one edge after.
        wait_e(19);
        push_exp(1, 31, 9'h00F, 1'b0, "lat_before_load");
        push_exp(1, 32, 9'h00F, 1'b1, "lat_update_p");
        push_exp(1, 33, 9'h1FF, 1'b0, "lat_all_on");
        applyStimulus(32'h0000_01FF);

        wait_e(34);
        push_exp(1, 48, 9'h1FF, 1'b1, "inv_update_p");
        push_exp(1, 49, 9'h1FA, 1'b0, "inv_mask");
        applyStimulus(32'h0000_0405);

        // Same decoded fields, only ignored bits differ.
        wait_e(50);
        push_exp(1, 64, 9'h1FA, 1'b0, "ignored_bits_no_upd");
        push_exp(1, 65, 9'h1FA, 1'b0, "ignored_bits_hold");
        applyStimulus(32'hFF00_0C05);

        wait_e(66);
        push_exp(1, 80, 9'h1FA, 1'b1, "dim12_update_p");
        for (int k = 81; k <= 96; k++)
            push_exp(1, k, (k >= 93) ? 9'h001 : 9'h000, 1'b0, "dim12_pwm");
        applyStimulus(32'h0000_C001);

        wait_e(97);
        push_exp(1, 112, 9'h001, 1'b1, "dim15_update_p");
        for (int k = 113; k <= 128; k++)
            push_exp(1, k, (k == 128) ? 9'h001 : 9'h000, 1'b0, "dim15_pwm");
        applyStimulus(32'h0000_F001);

        // Blink, half-period field 2: ticks at e%4==0, toggles every 3 ticks.
        wait_e(129);
        push_exp(1, 144, 9'h001, 1'b1, "blink_update_p");
        push_exp(1, 156, 9'h001, 1'b0, "blink_ph1_end");
        push_exp(1, 157, 9'h000, 1'b0, "blink_ph0_start");
        push_exp(1, 168, 9'h000, 1'b0, "blink_ph0_end");
        push_exp(1, 169, 9'h001, 1'b0, "blink_ph1_start");
        push_exp(1, 180, 9'h001, 1'b0, "blink_ph1_end2");
        push_exp(1, 181, 9'h000, 1'b0, "blink_ph0_start2");
        applyStimulus(32'h0002_0201);

        // Field lowered to 0 with count 1: toggle at the next tick (212), not 216.
        wait_e(193);
        push_exp(1, 208, 9'h000, 1'b1, "lower_update_p");
        push_exp(1, 212, 9'h000, 1'b0, "lower_before_tick");
        push_exp(1, 213, 9'h001, 1'b0, "lower_toggled");
        push_exp(1, 216, 9'h001, 1'b0, "fast_ph1_end");
        push_exp(1, 217, 9'h000, 1'b0, "fast_ph0_start");
        applyStimulus(32'h0000_0201);

        // Invert with blink so phase 0 shows as all LEDs lit.
        wait_e(218);
        push_exp(1, 224, 9'h001, 1'b1, "inv_blink_update_p");
        push_exp(1, 225, 9'h1FF, 1'b0, "inv_blink_ph0");
        applyStimulus(32'h0000_0601);

        wait_e(225);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        push_exp(1, 0, 9'h000, 1'b0, "mid_reset_async");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        epoch   = 2;
        push_exp(2, 1,  9'h00F, 1'b0, "post_reset_first");
        push_exp(2, 15, 9'h00F, 1'b0, "post_reset_hold");
        push_exp(2, 16, 9'h00F, 1'b1, "post_reset_update_p");
        push_exp(2, 17, 9'h1FE, 1'b0, "reenable_phase1");
        push_exp(2, 20, 9'h1FE, 1'b0, "reenable_phase1_end");
        push_exp(2, 21, 9'h1FF, 1'b0, "reenable_phase0");

        wait_e(22);
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s never checked (e=%0d epoch=%0d)", cur.name, cur.e, cur.epoch);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
